// File: rtl/flash_stream_reader.sv
// Multi-channel burst front-end for the QSPI flash byte engine.
// Round-robin bursts are streamed through a FIFO onto a channel-tagged output.
module flash_stream_reader #(
    parameter int NUM_CH          = 2,
    parameter int FLASH_SIZE_BITS = 24,
    parameter int LEN_BITS        = 16,
    parameter int FIFO_DEPTH      = 8,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH*FLASH_SIZE_BITS-1:0] req_addr,
    input  logic [NUM_CH*LEN_BITS-1:0]    req_len,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [NUM_CH-1:0]             abort,
    output logic [NUM_CH-1:0]             busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic [CH_W-1:0]               out_ch,
    output logic                          out_last,
    output logic [FLASH_SIZE_BITS-1:0]    eng_addr,
    output logic                          eng_do_read,
    input  logic                          eng_setup_done,
    input  logic                          eng_data_ready,
    input  logic [7:0]                    eng_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = CH_W + 9;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        STREAM,
        PAUSE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CH_W-1:0]            rr_ptr;
    logic [CH_W-1:0]            cur_ch;
    logic [FLASH_SIZE_BITS-1:0] cur_addr;
    logic [LEN_BITS-1:0]        remaining;

    logic                       gnt_found;
    logic [CH_W-1:0]            gnt_ch;
    logic [NUM_CH-1:0]          gnt_onehot;
    logic [FLASH_SIZE_BITS-1:0] gnt_addr;
    logic [LEN_BITS-1:0]        gnt_len;
    logic                       gnt_cancel;

    logic [NUM_CH-1:0]          cur_onehot;
    logic                       abort_cur;
    logic                       accept;
    logic                       last_byte;
    logic                       addr_top;

    logic [ENT_W-1:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           fifo_count;
    logic [CNT_W-1:0]           fifo_free;
    logic                       push;
    logic                       pop;

    // Search the channels after the RR pointer first, then wrap around.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_ch     = '0;
        gnt_onehot = '0;
        gnt_addr   = '0;
        gnt_len    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_found && req_valid[i] && i > int'(rr_ptr)) begin
                gnt_found     = 1'b1;
                gnt_ch        = CH_W'(i);
                gnt_onehot[i] = 1'b1;
                gnt_addr      = req_addr[i*FLASH_SIZE_BITS +: FLASH_SIZE_BITS];
                gnt_len       = req_len[i*LEN_BITS +: LEN_BITS];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!gnt_found && req_valid[i] && i <= int'(rr_ptr)) begin
                gnt_found     = 1'b1;
                gnt_ch        = CH_W'(i);
                gnt_onehot[i] = 1'b1;
                gnt_addr      = req_addr[i*FLASH_SIZE_BITS +: FLASH_SIZE_BITS];
                gnt_len       = req_len[i*LEN_BITS +: LEN_BITS];
            end
        end
    end

    assign gnt_cancel = |(abort & gnt_onehot);
    assign cur_onehot = NUM_CH'(1) << cur_ch;
    assign abort_cur  = (state != IDLE) && |(abort & cur_onehot);
    assign fifo_free  = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign last_byte  = (remaining == '0);
    assign addr_top   = &cur_addr;
    assign accept     = eng_do_read && eng_data_ready;
    assign push       = accept;
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (gnt_found && !gnt_cancel) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = abort_cur ? IDLE : STREAM;
            end
            STREAM: begin
                if (abort_cur) begin
                    state_next = IDLE;
                end else if (accept) begin
                    if (last_byte) begin
                        state_next = IDLE;
                    end else if (addr_top) begin
                        state_next = GAP;
                    end
                end else if (fifo_free == '0) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (abort_cur) begin
                    state_next = IDLE;
                end else if (fifo_free >= CNT_W'(FIFO_DEPTH / 2)) begin
                    state_next = GAP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        eng_do_read = 1'b0;
        if (state == IDLE && gnt_found && !rst) begin
            req_ready = gnt_onehot;
        end
        if (state == STREAM && eng_setup_done &&
            fifo_free != '0 && !abort_cur) begin
            eng_do_read = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= CH_W'(NUM_CH - 1);
            cur_ch    <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            busy      <= '0;
            eng_addr  <= '0;
        end else begin
            if (state == IDLE && gnt_found) begin
                rr_ptr    <= gnt_ch;
                cur_ch    <= gnt_ch;
                cur_addr  <= gnt_addr;
                remaining <= gnt_len;
                eng_addr  <= gnt_addr;
                busy      <= gnt_cancel ? '0 : gnt_onehot;
            end
            if (abort_cur) begin
                busy <= '0;
            end
            if (accept) begin
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
                if (last_byte) begin
                    busy <= '0;
                end else if (addr_top) begin
                    eng_addr <= '0;
                end
            end
            if (state == PAUSE && state_next == GAP) begin
                eng_addr <= cur_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cur_ch, last_byte, eng_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign out_valid = (fifo_count != '0);
    assign {out_ch, out_last, out_data} = mem[rd_ptr];

    // The engine only streams while a slot is free, so this never fires.
    assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Multi-channel burst front-end for the QSPI flash byte engine (qspi_flash core).
- NUM_CH clients post (address, length) burst requests. Bursts are served one at a time under round-robin arbitration.
- Read bytes pass through an internal FIFO to a shared, channel-tagged valid/ready output stream.
- The block pauses and re-addresses the engine on output backpressure and at flash address wrap-around; the single-stream reader cannot do either.

Parameters:
NUM_CH, 2, number of request channels (1..8)
FLASH_SIZE_BITS, 24, flash byte-address width
LEN_BITS, 16, burst length field width
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_CH  per-channel request pending
req_addr  in  NUM_CH*FLASH_SIZE_BITS  per-channel start address, packed with channel 0 in the LSBs
req_len  in  NUM_CH*LEN_BITS  per-channel byte count minus 1
req_ready  out  NUM_CH  one-cycle accept pulse; at most one bit set
abort  in  NUM_CH  cancel that channel's active burst
busy  out  NUM_CH  channel has an accepted, unfinished burst
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  8  byte
out_ch  out  $clog2(NUM_CH) (min 1)  channel tag
out_last  out  1  final byte of burst
eng_addr  out  FLASH_SIZE_BITS  engine start address
eng_do_read  out  1  engine streaming enable
eng_setup_done  in  1  engine ready for reads
eng_data_ready  in  1  byte valid; engine asserts it only while eng_do_read is high
eng_data  in  8  byte

Behaviour:
- Engine contract: raising eng_do_read after at least 1 low cycle starts sequential reads at eng_addr. eng_data_ready is ignored unless the block is in STREAM.
- Reset values: state IDLE, FIFO empty, out_valid=0, req_ready=0, busy=0, eng_do_read=0, RR pointer=NUM_CH-1, eng_addr=0.
- States:
  - IDLE: if any req_valid, grant the first channel after the RR pointer (cyclic). Pulse req_ready for it, latch addr/len into cur_addr/remaining, set cur_ch, busy[cur_ch]=1, RR pointer=cur_ch, go to GAP.
  - GAP: eng_do_read=0 and eng_addr=cur_addr for exactly one cycle, then go to STREAM.
  - STREAM: eng_do_read = eng_setup_done && fifo_free>=1. Each accepted byte pushes {cur_ch, remaining==0, eng_data}, increments cur_addr modulo 2^FLASH_SIZE_BITS, and decrements remaining. On the last byte: busy clears, go to IDLE.
  - PAUSE: entered from STREAM when fifo_free==0 and no byte is accepted that cycle. Return to GAP when fifo_free>=FIFO_DEPTH/2.
- Wrap-around: when an accepted byte came from address 2^FLASH_SIZE_BITS-1 and the burst is not done, go to GAP (re-address at 0) instead of continuing in STREAM.
- Latency: request accepted at cycle N; eng_do_read low at N+1; eng_do_read high at N+2 if eng_setup_done=1.
- FIFO:
  - Push and pop in the same cycle are both honoured.
  - out_* is a registered FIFO head and is stable while out_valid && !out_ready.
  - A push when full is impossible by construction; a debug assertion checks it.
- Abort:
  - abort[cur_ch] in GAP/STREAM/PAUSE: drop eng_do_read the same cycle, discard any byte arriving that cycle, clear busy, go to IDLE.
  - Bytes already in the FIFO are still delivered; no out_last is emitted for that burst.
  - abort on a non-active channel has no effect. An abort in the same cycle as req_ready for that channel cancels the new burst: busy stays 0.
- A channel must hold req_valid/addr/len until req_ready. A new request from a busy channel is not accepted until its burst finishes.
- rst mid-burst: everything returns to reset values in the next cycle; FIFO contents are lost.
- Length: req_len=0 means 1 byte; the maximum is 2^LEN_BITS bytes.

Test Plan:
- Single burst ch0, addr 0x000100, len 3: eng_do_read low at N+1, high at N+2; 4 bytes out with out_ch=0; out_last only on the 4th; busy[0] falls after the 4th push.
- Both channels request in the same cycle from reset: ch0 granted first, then ch1. Re-request both: ch0 granted again because the RR pointer advanced past ch1. Output bursts never interleave.
- out_ready=0, FIFO_DEPTH=8, len 19: exactly 8 bytes pushed, then PAUSE. Pop 4: GAP with eng_addr=start+8. All 20 bytes arrive in order with correct last.
- addr 0xFFFFFE, len 3: bytes from 0xFFFFFE and 0xFFFFFF, then a GAP with eng_addr=0x000000, then 2 more bytes.
- abort[1] mid-burst after 5 of 10 bytes: eng_do_read low the same cycle, busy[1]=0, no out_last for ch1. A pending ch0 request is granted next cycle.
- rst asserted during STREAM with 3 bytes in the FIFO: next cycle out_valid=0, eng_do_read=0, busy=0.
